// File: rtl/call_ret_predecode.sv
// Fetch-side call/return predecode in front of the return address stack.
// Classifies RV32 JAL/JALR as call/return/plain jump, drives the RAS
// push/pop/return-address controls, holds one registered slot toward
// decode and issues a one-cycle registered redirect to the next-PC mux.
// Optional: define STATIC_BRANCH_PRED_EN to predict backward conditional
// branches taken.
module call_ret_predecode #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned X5_LINK = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    output logic            ras_push,
    output logic            ras_pop,
    output logic [XLEN-1:0] ras_return_addr,
    input  logic [XLEN-1:0] ras_predicted_return,
    input  logic            ras_valid,
    output logic            pd_valid,
    input  logic            pd_ready,
    output logic [XLEN-1:0] pd_pc,
    output logic [31:0]     pd_instr,
    output logic [1:0]      pd_kind,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] KIND_OTHER = 2'b00;
    localparam logic [1:0] KIND_JAL   = 2'b01;
    localparam logic [1:0] KIND_CALL  = 2'b10;
    localparam logic [1:0] KIND_RET   = 2'b11;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned JIMM_W = 21;
    localparam int unsigned BIMM_W = 13;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic              is_jal;
    logic              is_jalr;
    logic              rd_link;
    logic              rs1_link;
    logic              accept;
    logic [JIMM_W-1:0] jal_imm;
    logic [XLEN-1:0]   jal_target;

    logic              push_c;
    logic              pop_c;
    logic [1:0]        kind_c;
    logic              redir_c;
    logic [XLEN-1:0]   target_c;

    assign opcode  = fetch_instr[6:0];
    assign funct3  = fetch_instr[14:12];
    assign rd      = fetch_instr[11:7];
    assign rs1     = fetch_instr[19:15];
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jalr = (opcode == OPC_JALR) && (funct3 == 3'b000);

    // x1 is always a link register; x5 only when X5_LINK is set
    assign rd_link  = (rd == 5'd1)  || ((X5_LINK != 0) && (rd == 5'd5));
    assign rs1_link = (rs1 == 5'd1) || ((X5_LINK != 0) && (rs1 == 5'd5));

    // handshake: slot can take a new entry when empty or draining this cycle
    assign fetch_ready = ~pd_valid | pd_ready;
    assign accept      = fetch_valid & fetch_ready & ~flush & ~reset;

    assign jal_imm    = {fetch_instr[31], fetch_instr[19:12], fetch_instr[20],
                         fetch_instr[30:21], 1'b0};
    assign jal_target = fetch_pc + {{(XLEN-JIMM_W){jal_imm[JIMM_W-1]}}, jal_imm};

`ifdef STATIC_BRANCH_PRED_EN
    logic              is_branch;
    logic [BIMM_W-1:0] br_imm;
    logic [XLEN-1:0]   br_target;

    assign is_branch = (opcode == OPC_BRANCH);
    assign br_imm    = {fetch_instr[31], fetch_instr[7], fetch_instr[30:25],
                        fetch_instr[11:8], 1'b0};
    assign br_target = fetch_pc + {{(XLEN-BIMM_W){br_imm[BIMM_W-1]}}, br_imm};
`endif

    // classify the offered instruction: RAS ops, slot kind and redirect target
    always_comb begin
        push_c   = 1'b0;
        pop_c    = 1'b0;
        kind_c   = KIND_OTHER;
        redir_c  = 1'b0;
        target_c = jal_target;
        if (is_jal) begin
            push_c  = rd_link;
            kind_c  = rd_link ? KIND_CALL : KIND_JAL;
            redir_c = 1'b1;
        end else if (is_jalr) begin
            if (rd_link) begin
                // rd!=rs1 with both links is a coroutine swap: replace top of stack
                push_c = 1'b1;
                pop_c  = rs1_link && (rd != rs1);
                kind_c = KIND_CALL;
            end else if (rs1_link) begin
                pop_c    = 1'b1;
                kind_c   = KIND_RET;
                redir_c  = ras_valid;
                target_c = ras_predicted_return;
            end
        end
`ifdef STATIC_BRANCH_PRED_EN
        else if (is_branch && fetch_instr[31]) begin
            redir_c  = 1'b1;
            target_c = br_target;
        end
`endif
    end

    assign ras_push        = accept & push_c;
    assign ras_pop         = accept & pop_c;
    assign ras_return_addr = fetch_pc + XLEN'(4);

    // output slot and one-cycle redirect pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pd_valid       <= 1'b0;
            pd_pc          <= '0;
            pd_instr       <= '0;
            pd_kind        <= KIND_OTHER;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept) begin
                pd_valid       <= 1'b1;
                pd_pc          <= fetch_pc;
                pd_instr       <= fetch_instr;
                pd_kind        <= kind_c;
                redirect_valid <= redir_c;
                if (redir_c) begin
                    redirect_pc <= target_c;
                end
            end else if (flush || pd_ready) begin
                pd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_call_ret_predecode.sv
// Self-checking bench for call_ret_predecode: directed scenarios plus a
// randomized run checked against a rule-level reference model.
module tb_call_ret_predecode;

    localparam int unsigned XLEN = 32;
    localparam int unsigned X5   = 1;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_return_addr;
    logic [31:0] ras_predicted_return;
    logic        ras_valid;
    logic        pd_valid;
    logic        pd_ready;
    logic [31:0] pd_pc;
    logic [31:0] pd_instr;
    logic [1:0]  pd_kind;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    // reference model state (what the registered outputs should hold)
    logic        m_pd_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [1:0]  m_kind;
    logic        m_rv;
    logic [31:0] m_rpc;

    call_ret_predecode #(.XLEN(XLEN), .X5_LINK(X5)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .fetch_valid          (fetch_valid),
        .fetch_ready          (fetch_ready),
        .fetch_pc             (fetch_pc),
        .fetch_instr          (fetch_instr),
        .ras_push             (ras_push),
        .ras_pop              (ras_pop),
        .ras_return_addr      (ras_return_addr),
        .ras_predicted_return (ras_predicted_return),
        .ras_valid            (ras_valid),
        .pd_valid             (pd_valid),
        .pd_ready             (pd_ready),
        .pd_pc                (pd_pc),
        .pd_instr             (pd_instr),
        .pd_kind              (pd_kind),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_link(input int r);
        return (r == 1) || (X5 != 0 && r == 5);
    endfunction

    // rule-level reference: RAS ops, kind, redirect and target for one instruction
    function automatic void classify(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic rv, input logic [31:0] pred,
                                     output logic push, output logic pop,
                                     output logic [1:0] kind, output logic redir,
                                     output logic [31:0] tgt);
        int opc, f3, rd, rs1, off;
        opc = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        push = 0; pop = 0; kind = 2'd0; redir = 0; tgt = 32'd0;
        if (opc == 'h6F) begin
            off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                  - (ins[31] ? (1 << 20) : 0);
            push  = is_link(rd);
            kind  = is_link(rd) ? 2'd2 : 2'd1;
            redir = 1;
            tgt   = pc + 32'(off);
        end else if (opc == 'h67 && f3 == 0) begin
            if (!is_link(rd) && is_link(rs1)) begin
                pop = 1; kind = 2'd3; redir = rv; tgt = pred;
            end else if (is_link(rd)) begin
                push = 1; kind = 2'd2;
                pop  = is_link(rs1) && (rd != rs1);
            end
        end
`ifdef STATIC_BRANCH_PRED_EN
        else if (opc == 'h63 && ins[31]) begin
            off = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - 4096;
            redir = 1;
            tgt   = pc + 32'(off);
        end
`endif
    endfunction

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, input logic rv,
                         input logic [31:0] pred);
        fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; pd_ready = rdy;
        flush = fl; ras_valid = rv; ras_predicted_return = pred;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        m_pd_valid = 0; m_pc = 0; m_instr = 0; m_kind = 0; m_rv = 0; m_rpc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 32'h100, 32'h008000EF, 0, 0, 0, 0);
        tick();
        total++; if (pd_valid !== 1'b1) begin bad++; $display("FAIL reset_preload pd_valid got=%0b exp=1", pd_valid); end
        reset = 1'b1;
        #1;
        total++; if (ras_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%0b exp=0", ras_push); end
        tick();
        total++; if (pd_valid !== 1'b0) begin bad++; $display("FAIL reset_pd_valid got=%0b exp=0", pd_valid); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redir_valid got=%0b exp=0", redirect_valid); end
        total++; if (pd_pc !== 32'h0) begin bad++; $display("FAIL reset_pd_pc got=%h exp=0", pd_pc); end
        total++; if (pd_instr !== 32'h0) begin bad++; $display("FAIL reset_pd_instr got=%h exp=0", pd_instr); end
        total++; if (pd_kind !== 2'b00) begin bad++; $display("FAIL reset_pd_kind got=%b exp=00", pd_kind); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redir_pc got=%h exp=0", redirect_pc); end
        reset = 1'b0;
    endtask

    task automatic test_call();
        do_reset();
        drive(1, 32'h100, 32'h008000EF, 1, 0, 0, 0);
        #1;
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL call_ready got=%0b exp=1", fetch_ready); end
        total++; if (ras_push !== 1'b1 || ras_pop !== 1'b0) begin bad++; $display("FAIL call_ras push=%0b pop=%0b exp=1/0", ras_push, ras_pop); end
        total++; if (ras_return_addr !== 32'h104) begin bad++; $display("FAIL call_ret_addr got=%h exp=104", ras_return_addr); end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (pd_valid !== 1'b1 || pd_kind !== 2'b10) begin bad++; $display("FAIL call_slot valid=%0b kind=%b exp=1/10", pd_valid, pd_kind); end
        total++; if (pd_pc !== 32'h100 || pd_instr !== 32'h008000EF) begin bad++; $display("FAIL call_slot_data pc=%h instr=%h", pd_pc, pd_instr); end
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h108) begin bad++; $display("FAIL call_redirect v=%0b pc=%h exp=1/108", redirect_valid, redirect_pc); end
        tick();
        total++; if (redirect_valid !== 1'b0 || pd_valid !== 1'b0) begin bad++; $display("FAIL call_pulse rv=%0b pv=%0b exp=0/0", redirect_valid, pd_valid); end
        total++; if (redirect_pc !== 32'h108) begin bad++; $display("FAIL call_redir_hold got=%h exp=108", redirect_pc); end
    endtask

    task automatic test_return();
        do_reset();
        drive(1, 32'h200, 32'h00008067, 1, 0, 1, 32'h104);
        #1;
        total++; if (ras_pop !== 1'b1 || ras_push !== 1'b0) begin bad++; $display("FAIL ret_ras pop=%0b push=%0b exp=1/0", ras_pop, ras_push); end
        tick();
        drive(1, 32'h200, 32'h00008067, 1, 0, 0, 32'h888);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin bad++; $display("FAIL ret_redirect v=%0b pc=%h exp=1/104", redirect_valid, redirect_pc); end
        total++; if (pd_kind !== 2'b11) begin bad++; $display("FAIL ret_kind got=%b exp=11", pd_kind); end
        #1;
        total++; if (ras_pop !== 1'b1) begin bad++; $display("FAIL ret_empty_pop got=%0b exp=1", ras_pop); end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (redirect_valid !== 1'b0 || pd_kind !== 2'b11 || pd_valid !== 1'b1) begin bad++; $display("FAIL ret_empty rv=%0b kind=%b pv=%0b exp=0/11/1", redirect_valid, pd_kind, pd_valid); end
        total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL ret_empty_hold got=%h exp=104", redirect_pc); end
    endtask

    task automatic test_coroutine();
        do_reset();
        drive(1, 32'h300, 32'h000280E7, 1, 0, 1, 32'h500);
        #1;
        total++; if (ras_push !== 1'b1 || ras_pop !== 1'b1) begin bad++; $display("FAIL swap_ras push=%0b pop=%0b exp=1/1", ras_push, ras_pop); end
        total++; if (ras_return_addr !== 32'h304) begin bad++; $display("FAIL swap_ret_addr got=%h exp=304", ras_return_addr); end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (pd_kind !== 2'b10 || redirect_valid !== 1'b0) begin bad++; $display("FAIL swap_slot kind=%b rv=%0b exp=10/0", pd_kind, redirect_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 32'h100, 32'h008000EF, 0, 0, 0, 0);
        tick();
        drive(1, 32'h400, 32'h008000EF, 0, 0, 0, 0);
        #1;
        total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", fetch_ready); end
        total++; if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin bad++; $display("FAIL bp_ras push=%0b pop=%0b exp=0/0", ras_push, ras_pop); end
        tick();
        tick();
        total++; if (pd_valid !== 1'b1 || pd_pc !== 32'h100 || redirect_valid !== 1'b0) begin bad++; $display("FAIL bp_hold pv=%0b pc=%h rv=%0b exp=1/100/0", pd_valid, pd_pc, redirect_valid); end
        pd_ready = 1'b1;
        #1;
        total++; if (fetch_ready !== 1'b1 || ras_push !== 1'b1) begin bad++; $display("FAIL bp_release ready=%0b push=%0b exp=1/1", fetch_ready, ras_push); end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (pd_pc !== 32'h400 || redirect_pc !== 32'h408) begin bad++; $display("FAIL bp_next pc=%h rpc=%h exp=400/408", pd_pc, redirect_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 32'h100, 32'h008000EF, 1, 1, 0, 0);
        #1;
        total++; if (ras_push !== 1'b0) begin bad++; $display("FAIL flush_push got=%0b exp=0", ras_push); end
        tick();
        total++; if (pd_valid !== 1'b0 || redirect_valid !== 1'b0) begin bad++; $display("FAIL flush_accept pv=%0b rv=%0b exp=0/0", pd_valid, redirect_valid); end
        drive(1, 32'h100, 32'h008000EF, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
        total++; if (pd_valid !== 1'b0) begin bad++; $display("FAIL flush_held pv=%0b exp=0", pd_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 32'hFFFFFFFC, 32'h004000EF, 1, 0, 0, 0);
        #1;
        total++; if (ras_push !== 1'b1 || ras_return_addr !== 32'h0) begin bad++; $display("FAIL wrap_ret push=%0b addr=%h exp=1/0", ras_push, ras_return_addr); end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redirect v=%0b pc=%h exp=1/0", redirect_valid, redirect_pc); end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom());
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ins, pc, pred;
        logic        fv, rdy, fl, rv, push, pop, redir, exp_ready, acc;
        logic [1:0]  kind;
        logic [31:0] tgt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ins = $urandom();
            case ($urandom_range(0, 4))
                0: begin ins[6:0] = 7'h6F; ins[11:7] = pick_reg(); end
                1: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; ins[11:7] = pick_reg(); ins[19:15] = pick_reg(); end
                2: begin ins[6:0] = 7'h67; ins[14:12] = 3'($urandom_range(1, 7)); ins[19:15] = pick_reg(); end
                3: ins[6:0] = 7'h63;
                default: ;
            endcase
            pc   = $urandom() & 32'hFFFF_FFFC;
            pred = $urandom();
            fv   = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 9) == 0);
            rv   = $urandom_range(0, 1);
            drive(fv, pc, ins, rdy, fl, rv, pred);
            #1;
            classify(ins, pc, rv, pred, push, pop, kind, redir, tgt);
            exp_ready = ~m_pd_valid | rdy;
            acc = fv & exp_ready & ~fl;
            total++; if (fetch_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, fetch_ready, exp_ready); end
            total++; if (ras_push !== (acc & push) || ras_pop !== (acc & pop)) begin bad++; $display("FAIL rnd_ras n=%0d ins=%h push=%0b pop=%0b exp=%0b/%0b", n, ins, ras_push, ras_pop, acc & push, acc & pop); end
            if (acc && push) begin
                total++; if (ras_return_addr !== pc + 32'd4) begin bad++; $display("FAIL rnd_ret_addr n=%0d got=%h exp=%h", n, ras_return_addr, pc + 32'd4); end
            end
            if (acc) begin
                m_pd_valid = 1; m_pc = pc; m_instr = ins; m_kind = kind; m_rv = redir;
                if (redir) m_rpc = tgt;
            end else begin
                if (fl || rdy) m_pd_valid = 0;
                m_rv = 0;
            end
            tick();
            total++; if (pd_valid !== m_pd_valid || redirect_valid !== m_rv) begin bad++; $display("FAIL rnd_valid n=%0d pv=%0b rv=%0b exp=%0b/%0b", n, pd_valid, redirect_valid, m_pd_valid, m_rv); end
            total++; if (pd_pc !== m_pc || pd_instr !== m_instr || pd_kind !== m_kind) begin bad++; $display("FAIL rnd_slot n=%0d pc=%h ins=%h kind=%b exp=%h/%h/%b", n, pd_pc, pd_instr, pd_kind, m_pc, m_instr, m_kind); end
            total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL rnd_redir_pc n=%0d got=%h exp=%h", n, redirect_pc, m_rpc); end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0);
        test_reset();
        test_call();
        test_return();
        test_coroutine();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_ret_predecode.md
Name: call_ret_predecode

Overview:
- Fetch-side predecode stage that sits directly upstream of the return address stack.
- Classifies each fetched RV32 instruction as call, return, JAL or other, and drives the RAS push/pop/return_addr controls.
- Captures the RAS predicted return or the JAL target into a one-entry registered output slot, with a valid/ready handshake toward decode.
- Emits a registered redirect request to the next-PC mux.

Parameters:
- XLEN, 32, datapath width; must equal riscv_pkg XLEN.
- X5_LINK, 1, 1: x5 and x1 are both link registers; 0: only x1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush; kills the held slot and the current accept
- fetch_valid  in  1  fetch offers an instruction
- fetch_ready  out  1  stage can accept this cycle
- fetch_pc  in  XLEN  PC of the offered instruction
- fetch_instr  in  32  offered instruction word
- ras_push  out  1  to RAS push
- ras_pop  out  1  to RAS pop
- ras_return_addr  out  XLEN  to RAS return_addr
- ras_predicted_return  in  XLEN  from RAS, top of stack
- ras_valid  in  1  from RAS, stack non-empty
- pd_valid  out  1  held slot valid toward decode
- pd_ready  in  1  decode accepts the slot
- pd_pc  out  XLEN  held PC
- pd_instr  out  32  held instruction
- pd_kind  out  2  00 other, 01 jal_plain, 10 call, 11 return
- redirect_valid  out  1  one-cycle registered redirect request
- redirect_pc  out  XLEN  redirect target

Behaviour:
- accept = fetch_valid & fetch_ready & ~flush.
- fetch_ready = ~pd_valid | pd_ready. It is combinational and does not depend on fetch_valid.
- Link register test: link(r) = (r==1) | (X5_LINK & r==5).
- Decode fields: opcode 1101111 = JAL; opcode 1100111 with funct3 000 = JALR.
- Classification (rd, rs1 from instr[11:7], instr[19:15]):
  - JAL, link(rd): push, kind=call.
  - JAL, ~link(rd): no RAS op, kind=jal_plain.
  - JALR, ~link(rd) & link(rs1): pop, kind=return.
  - JALR, link(rd) & ~link(rs1): push, kind=call.
  - JALR, link(rd) & link(rs1) & rd!=rs1: push and pop together (RAS replaces top), kind=call.
  - JALR, link(rd) & link(rs1) & rd==rs1: push, kind=call.
  - JALR, neither is a link: no RAS op, kind=other.
  - Everything else: kind=other.
- RAS controls:
  - ras_push/ras_pop are combinational from fetch_instr, gated by accept. They are 0 whenever accept=0.
  - ras_return_addr = fetch_pc + 4, with wrap modulo 2^XLEN; it is don't-care when push=0.
- Redirect target, computed on accept and registered the same edge as the slot load:
  - JAL (either kind): fetch_pc + sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), mod 2^XLEN.
  - return with ras_valid=1: ras_predicted_return, sampled combinationally before the pop takes effect.
  - return with ras_valid=0: no redirect; the pop is still issued (RAS ignores pop on empty).
  - Other JALR: no redirect.
- Slot register:
  - On accept: pd_valid<=1 and pd_pc/pd_instr/pd_kind load.
  - Else if pd_ready: pd_valid<=0.
  - Data is held stable while pd_valid & ~pd_ready.
- redirect_valid:
  - Set for exactly one cycle on the edge that loads a redirecting instruction; 0 otherwise.
  - redirect_pc holds its value until the next redirect.
- Flush:
  - Synchronous. Next cycle pd_valid=0 and redirect_valid=0.
  - No RAS op is issued in the flush cycle.
  - Flush has priority over accept.
- Reset:
  - pd_valid=0, redirect_valid=0, pd_pc=0, pd_instr=0 (NOP not required), pd_kind=00, redirect_pc=0.
  - ras_push/ras_pop are 0 during reset.
  - Reset mid-handshake drops the held slot.
- Latency: 1 cycle from accept to pd_valid/redirect_valid. Full throughput when pd_ready is held 1.

Optional Feature:
- Macro: STATIC_BRANCH_PRED_EN.
- Defined:
  - Conditional branches (opcode 1100011) with negative B-immediate are predicted taken.
  - redirect_valid pulses with redirect_pc = fetch_pc + sext(B-imm).
  - pd_kind=00; no RAS op.
- Undefined: branches produce no redirect and the adder logic is absent.

Test Plan:
- Call: pc=0x100, instr=0x008000EF (jal x1,+8), pd_ready=1 -> same cycle ras_push=1, ras_return_addr=0x104; next cycle pd_valid=1, pd_kind=10, redirect_valid=1, redirect_pc=0x108.
- Return: pc=0x200, instr=0x00008067 (jalr x0,0(x1)), ras_valid=1, ras_predicted_return=0x104 -> ras_pop=1, ras_push=0; next cycle redirect_pc=0x104, pd_kind=11.
- Return on empty RAS: same instr with ras_valid=0 -> ras_pop=1; next cycle redirect_valid=0, pd_kind=11.
- Coroutine swap: instr=0x000280E7 (jalr x1,0(x5)), pc=0x300, X5_LINK=1 -> ras_push=1 and ras_pop=1 together, ras_return_addr=0x304.
- Backpressure and flush:
  - Hold pd_ready=0 with a slot valid -> fetch_ready=0, no RAS ops on offered calls, slot data stable.
  - Assert flush with fetch_valid=1 on a call -> ras_push=0; next cycle pd_valid=0.
- Wrap: pc=0xFFFFFFFC, jal x1,+4 -> ras_return_addr=0x00000000, redirect_pc=0x00000000.
